// File: rtl/uart_tx_seq.sv
// uart_tx_seq: APB master that configures a UART (five register writes) and
// then streams bytes into its DATA register, polling STATUS for FIFO space.
module uart_tx_seq #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_GAP  = 4
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [6:0]  cfg_con,
  input  logic [2:0]  cfg_se,
  input  logic [7:0]  cfg_brg,
  input  logic [4:0]  cfg_ie,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [31:0] m_paddr,
  output logic [31:0] m_pwdata,
  input  logic [31:0] m_prdata,
  output logic        cfg_done,
  output logic        busy,
  output logic [15:0] byte_cnt
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;
  localparam logic [AW-1:0] OFF_CON    = 32'h0000_0000;
  localparam logic [AW-1:0] OFF_SE     = 32'h0000_0004;
  localparam logic [AW-1:0] OFF_BRG    = 32'h0000_0008;
  localparam logic [AW-1:0] OFF_DATA   = 32'h0000_000C;
  localparam logic [AW-1:0] OFF_IE     = 32'h0000_0010;
  localparam logic [2:0]    LAST_STEP  = 3'd4;
  localparam int unsigned   TXNF_BIT   = 5;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_SETUP, S_CFG_ACCESS, S_RUN, S_POLL_SETUP,
    S_POLL_ACCESS, S_GAP, S_WR_SETUP, S_WR_ACCESS
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [7:0]    gap_q, gap_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [6:0]    con_q, con_d;
  logic [2:0]    se_q, se_d;
  logic [7:0]    brg_q, brg_d;
  logic [4:0]    ie_q, ie_d;
  logic          stop_pend_q, stop_pend_d;
  logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic          tx_ready_q, tx_ready_d, cfg_done_q, cfg_done_d, busy_q, busy_d;
  logic          prdata_unused;

  assign prdata_unused = ^{m_prdata[31:TXNF_BIT+1], m_prdata[TXNF_BIT-1:0]};

  // State and registered outputs
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      gap_q       <= '0;
      byte_cnt_q  <= '0;
      con_q       <= '0;
      se_q        <= '0;
      brg_q       <= '0;
      ie_q        <= '0;
      stop_pend_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      tx_ready_q  <= 1'b0;
      cfg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      gap_q       <= gap_d;
      byte_cnt_q  <= byte_cnt_d;
      con_q       <= con_d;
      se_q        <= se_d;
      brg_q       <= brg_d;
      ie_q        <= ie_d;
      stop_pend_q <= stop_pend_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      tx_ready_q  <= tx_ready_d;
      cfg_done_q  <= cfg_done_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; a stop seen in a SETUP phase is remembered until its ACCESS ends
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    gap_d       = gap_q;
    byte_cnt_d  = byte_cnt_q;
    con_d       = con_q;
    se_d        = se_q;
    brg_d       = brg_q;
    ie_d        = ie_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          state_d    = S_CFG_SETUP;
          step_d     = '0;
          byte_cnt_d = '0;
          con_d      = cfg_con;
          se_d       = cfg_se;
          brg_d      = cfg_brg;
          ie_d       = cfg_ie;
        end
      end
      S_CFG_SETUP: begin
        state_d = S_CFG_ACCESS;
        if (stop) stop_pend_d = 1'b1;
      end
      S_CFG_ACCESS: begin
        stop_pend_d = 1'b0;
        if (stop || stop_pend_q) begin
          state_d = S_IDLE;
          step_d  = '0;
        end else if (step_q == LAST_STEP) begin
          state_d = S_RUN;
          step_d  = '0;
        end else begin
          state_d = S_CFG_SETUP;
          step_d  = step_q + 3'd1;
        end
      end
      S_RUN: begin
        if (stop)          state_d = S_IDLE;
        else if (tx_valid) state_d = S_POLL_SETUP;
      end
      S_POLL_SETUP: begin
        state_d = S_POLL_ACCESS;
        if (stop) stop_pend_d = 1'b1;
      end
      S_POLL_ACCESS: begin
        stop_pend_d = 1'b0;
        if (stop || stop_pend_q)    state_d = S_IDLE;
        else if (!tx_valid)         state_d = S_RUN;
        else if (m_prdata[TXNF_BIT]) state_d = S_WR_SETUP;
        else begin
          state_d = S_GAP;
          gap_d   = 8'(POLL_GAP);
        end
      end
      S_GAP: begin
        if (stop || !tx_valid) begin
          state_d = stop ? S_IDLE : S_RUN;
          gap_d   = '0;
        end else if (gap_q <= 8'd1) begin
          state_d = S_POLL_SETUP;
          gap_d   = '0;
        end else begin
          gap_d   = gap_q - 8'd1;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_ACCESS;
        if (stop) stop_pend_d = 1'b1;
      end
      S_WR_ACCESS: begin
        stop_pend_d = 1'b0;
        byte_cnt_d  = byte_cnt_q + 16'd1;
        state_d     = (stop || stop_pend_q) ? S_IDLE : S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so outputs line up with state_q
  always_comb begin
    psel_d     = 1'b0;
    penable_d  = 1'b0;
    pwrite_d   = 1'b0;
    paddr_d    = '0;
    pwdata_d   = '0;
    tx_ready_d = 1'b0;
    cfg_done_d = 1'b0;
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_CFG_SETUP, S_CFG_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == S_CFG_ACCESS);
        pwrite_d  = 1'b1;
        case (step_d)
          3'd0:    begin paddr_d = BASE_ADDR + OFF_SE;  pwdata_d = '0; end
          3'd1:    begin paddr_d = BASE_ADDR + OFF_BRG; pwdata_d = 32'(brg_d); end
          3'd2:    begin paddr_d = BASE_ADDR + OFF_CON; pwdata_d = 32'(con_d); end
          3'd3:    begin paddr_d = BASE_ADDR + OFF_IE;  pwdata_d = 32'(ie_d); end
          default: begin paddr_d = BASE_ADDR + OFF_SE;  pwdata_d = 32'(se_d); end
        endcase
      end
      S_POLL_SETUP, S_POLL_ACCESS: begin
        psel_d     = 1'b1;
        penable_d  = (state_d == S_POLL_ACCESS);
        paddr_d    = BASE_ADDR + OFF_SE;
        cfg_done_d = 1'b1;
      end
      S_WR_SETUP, S_WR_ACCESS: begin
        psel_d     = 1'b1;
        penable_d  = (state_d == S_WR_ACCESS);
        pwrite_d   = 1'b1;
        paddr_d    = BASE_ADDR + OFF_DATA;
        pwdata_d   = 32'(tx_data);
        tx_ready_d = (state_d == S_WR_ACCESS);
        cfg_done_d = 1'b1;
      end
      S_RUN, S_GAP: cfg_done_d = 1'b1;
      default: ;
    endcase
  end

  assign m_psel    = psel_q;
  assign m_penable = penable_q;
  assign m_pwrite  = pwrite_q;
  assign m_paddr   = paddr_q;
  assign m_pwdata  = pwdata_q;
  assign tx_ready  = tx_ready_q;
  assign cfg_done  = cfg_done_q;
  assign busy      = busy_q;
  assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_uart_tx_seq.sv
// Bench for uart_tx_seq: directed stimulus pushes expected APB writes into a
// queue; a monitor on the falling edge pops and compares every transfer.
module tb_uart_tx_seq;

  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam int unsigned GAP  = 4;

  logic        pclk = 1'b0, prst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [6:0]  cfg_con = '0;
  logic [2:0]  cfg_se = '0;
  logic [7:0]  cfg_brg = '0;
  logic [4:0]  cfg_ie = '0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_ready, m_psel, m_penable, m_pwrite, cfg_done, busy;
  logic [31:0] m_paddr, m_pwdata, m_prdata;
  logic [15:0] byte_cnt;

  typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  int   poll_t[$];
  int   n_vec = 0, n_err = 0, cyc = 0, rd_cnt = 0, nf_until = 0;
  logic [31:0] su_addr, su_data;
  logic        su_wr;

  uart_tx_seq #(.BASE_ADDR(BASE), .POLL_GAP(GAP)) dut (
    .pclk(pclk), .prst_n(prst_n), .start(start), .stop(stop),
    .cfg_con(cfg_con), .cfg_se(cfg_se), .cfg_brg(cfg_brg), .cfg_ie(cfg_ie),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .cfg_done(cfg_done), .busy(busy), .byte_cnt(byte_cnt)
  );

  always #5 pclk = ~pclk;

  // STATUS model: FIFO reported full until rd_cnt reaches nf_until
  assign m_prdata = (rd_cnt >= nf_until) ? 32'h0000_0020 : 32'h0000_0000;

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (m_psel && m_penable && !m_pwrite) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard for writes, fixed expectations for reads and idle bus
  always @(negedge pclk) begin
    if (prst_n) begin
      if (m_psel && !m_penable) begin
        su_addr = m_paddr; su_data = m_pwdata; su_wr = m_pwrite;
        if (!m_pwrite) poll_t.push_back(cyc);
      end else if (m_psel && m_penable) begin
        check("apb_stable_addr", m_paddr, su_addr);
        check("apb_stable_data", m_pwdata, su_data);
        check("apb_stable_wr", 32'(m_pwrite), 32'(su_wr));
        if (m_pwrite) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", m_paddr, 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_addr", m_paddr, e.addr);
            check("wr_data", m_pwdata, e.data);
            check("wr_tx_ready", 32'(tx_ready), 32'(e.addr == BASE + 32'hC));
          end
        end else begin
          check("rd_addr", m_paddr, BASE + 32'h4);
          check("rd_tx_ready", 32'(tx_ready), 32'd0);
        end
      end else begin
        check("idle_bus", {29'd0, tx_ready, m_penable, m_pwrite} | m_paddr | m_pwdata, 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [31:0] off, input logic [31:0] data);
    exp_t e;
    e.addr = BASE + off;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic cfg_seq(input logic [2:0] se, input logic [7:0] brg, input logic [6:0] con,
                         input logic [4:0] ie, input logic with_stop);
    int s;
    push_exp(32'h04, 32'h0);
    push_exp(32'h08, 32'(brg));
    push_exp(32'h00, 32'(con));
    push_exp(32'h10, 32'(ie));
    push_exp(32'h04, 32'(se));
    @(negedge pclk);
    cfg_se = se; cfg_brg = brg; cfg_con = con; cfg_ie = ie;
    start = 1'b1; stop = with_stop; s = cyc;
    @(negedge pclk);
    start = 1'b0; stop = 1'b0;
    cfg_se = ~se; cfg_brg = ~brg; cfg_con = ~con; cfg_ie = ~ie;
    check("cfg_busy", 32'(busy), 32'd1);
    check("cfg_byte_cnt_clr", 32'(byte_cnt), 32'd0);
    repeat (9) @(negedge pclk);
    check("cfg_done_early", 32'(cfg_done), 32'd0);
    @(negedge pclk);
    check("cfg_len", 32'(cyc - s), 32'd11);
    check("cfg_done", 32'(cfg_done), 32'd1);
    check("cfg_all_writes", 32'(exp_q.size()), 32'd0);
  endtask

  // Offer one byte; returns at the falling edge where tx_ready is seen
  task automatic wait_ready(input string name, input int n, input int lat);
    int k;
    k = 0;
    while (!tx_ready && k < 300) begin
      @(negedge pclk);
      k++;
    end
    if (!tx_ready) check({name, "_timeout"}, 32'd0, 32'd1);
    else           check(name, 32'(cyc - n), 32'(lat));
  endtask

  task automatic send_byte(input logic [7:0] d, input int lat);
    int n;
    push_exp(32'h0C, 32'(d));
    @(negedge pclk);
    tx_valid = 1'b1; tx_data = d; n = cyc;
    @(negedge pclk);
    wait_ready("latency", n, lat);
    tx_valid = 1'b0;
  endtask

  initial begin
    int n, k;
    // Reset state
    repeat (3) @(negedge pclk);
    check("rst_ctrl", {26'd0, m_psel, m_penable, m_pwrite, tx_ready, cfg_done, busy}, 32'd0);
    check("rst_addr", m_paddr | m_pwdata, 32'd0);
    check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    prst_n = 1'b1;
    @(negedge pclk);
    check("post_rst_idle", 32'(busy), 32'd0);

    // Configuration sequence (cfg inputs scrambled after start)
    cfg_seq(3'b001, 8'h1A, 7'h05, 5'h03, 1'b0);

    // Single byte, FIFO has space
    nf_until = rd_cnt;
    send_byte(8'h55, 4);
    @(negedge pclk);
    check("byte_cnt_1", 32'(byte_cnt), 32'd1);

    // Back-to-back bytes: second tx_ready five cycles after the first
    push_exp(32'h0C, 32'h0000_00A1);
    push_exp(32'h0C, 32'h0000_00B2);
    tx_valid = 1'b1; tx_data = 8'hA1; n = cyc;
    @(negedge pclk);
    wait_ready("b2b_first", n, 4);
    tx_data = 8'hB2;
    @(negedge pclk);
    wait_ready("b2b_second", n, 9);
    tx_valid = 1'b0;
    @(negedge pclk);
    check("byte_cnt_3", 32'(byte_cnt), 32'd3);

    // FIFO full for three polls, then space
    nf_until = rd_cnt + 3;
    poll_t.delete();
    send_byte(8'hC3, 4 + 3 * (2 + GAP));
    check("poll_count", 32'(poll_t.size()), 32'd4);
    for (int i = 1; i < poll_t.size(); i++)
      check("poll_spacing", 32'(poll_t[i] - poll_t[i-1]), 32'(2 + GAP));
    @(negedge pclk);
    check("byte_cnt_4", 32'(byte_cnt), 32'd4);

    // tx_valid withdrawn while polling a full FIFO: back to RUN, no write
    nf_until = rd_cnt + 1000;
    tx_valid = 1'b1; tx_data = 8'h77;
    repeat (7) @(negedge pclk);
    tx_valid = 1'b0;
    repeat (3) @(negedge pclk);
    poll_t.delete();
    repeat (10) @(negedge pclk);
    check("abort_no_poll", 32'(poll_t.size()), 32'd0);
    check("abort_run", {30'd0, busy, cfg_done}, 32'd3);
    check("abort_byte_cnt", 32'(byte_cnt), 32'd4);
    nf_until = rd_cnt;

    // byte_cnt wrap
    force dut.byte_cnt_q = 16'hFFFF;
    #1 release dut.byte_cnt_q;
    @(negedge pclk);
    check("preset_cnt", 32'(byte_cnt), 32'h0000_FFFF);
    send_byte(8'hAA, 4);
    @(negedge pclk);
    check("byte_cnt_wrap", 32'(byte_cnt), 32'd0);

    // stop during WR_SETUP: access completes with tx_ready, then IDLE
    push_exp(32'h0C, 32'h0000_003C);
    tx_valid = 1'b1; tx_data = 8'h3C;
    k = 0;
    while (!(m_psel && !m_penable && m_pwrite) && k < 50) begin
      @(negedge pclk);
      k++;
    end
    check("wr_setup_seen", {30'd0, m_psel, m_pwrite}, 32'd3);
    stop = 1'b1;
    @(negedge pclk);
    stop = 1'b0;
    check("stop_tx_ready", 32'(tx_ready), 32'd1);
    tx_valid = 1'b0;
    @(negedge pclk);
    check("stop_idle", {30'd0, busy, cfg_done}, 32'd0);
    check("stop_byte_cnt", 32'(byte_cnt), 32'd1);

    // start and stop together in IDLE: start wins; then stop in RUN
    cfg_seq(3'b011, 8'h22, 7'h11, 5'h1F, 1'b1);
    @(negedge pclk);
    stop = 1'b1;
    @(negedge pclk);
    stop = 1'b0;
    check("stop_run_idle", {30'd0, busy, cfg_done}, 32'd0);

    // Reset during CFG_ACCESS step 2, then a fresh start from step 0
    push_exp(32'h04, 32'h0);
    push_exp(32'h08, 32'h0000_0033);
    push_exp(32'h00, 32'h0000_0044);
    push_exp(32'h10, 32'h0000_0005);
    push_exp(32'h04, 32'h0000_0001);
    cfg_se = 3'b001; cfg_brg = 8'h33; cfg_con = 7'h44; cfg_ie = 5'h05;
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    repeat (5) @(negedge pclk);
    check("step2_access", {m_paddr[30:0], m_penable}, {BASE[30:0], 1'b1});
    #1 prst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {28'd0, m_psel, m_penable, busy, cfg_done}, 32'd0);
    check("rst_mid_cnt", 32'(byte_cnt), 32'd0);
    check("rst_mid_left", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    repeat (2) @(negedge pclk);
    prst_n = 1'b1;
    cfg_seq(3'b101, 8'h66, 7'h7F, 5'h10, 1'b0);
    send_byte(8'h0F, 4);
    @(negedge pclk);
    check("final_byte_cnt", 32'(byte_cnt), 32'd1);

    repeat (3) @(negedge pclk);
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_seq.md
UART_TX_SEQ -- requirements
Module: uart_tx_seq

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, base address of the UART APB register map.
REQ-002 Parameter POLL_GAP, default 4, idle cycles between a status poll that finds the TX FIFO full and the next poll; legal range 1..255.
REQ-003 pclk  in  1  clock; all state changes on rising edge.
REQ-004 prst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; begin configuration sequence (honoured only in IDLE).
REQ-006 stop  in  1  level/pulse; return to IDLE after the current APB transfer completes.
REQ-007 cfg_con  in  7  value for CON register (offset 0x00).
REQ-008 cfg_se  in  3  value for SE register (offset 0x04); bit0 = UART enable.
REQ-009 cfg_brg  in  8  value for BRG register (offset 0x08).
REQ-010 cfg_ie  in  5  value for IE register (offset 0x10).
REQ-011 tx_valid  in  1  byte available on tx_data.
REQ-012 tx_data  in  8  byte to transmit; held stable while tx_valid=1 and tx_ready=0.
REQ-013 tx_ready  out  1  one-cycle pulse; byte accepted (written to UART DATA).
REQ-014 m_psel, m_penable, m_pwrite  out  1 each  APB master controls.
REQ-015 m_paddr  out  32  APB address = BASE_ADDR + offset.
REQ-016 m_pwdata  out  32  APB write data, unused bits zero.
REQ-017 m_prdata  in  32  APB read data; bit5 of STATUS (0x04) = TX FIFO not full.
REQ-018 cfg_done  out  1  high while in streaming states (configuration complete).
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 byte_cnt  out  16  bytes accepted since last start.

Function
REQ-021 APB transfers SHALL be fixed two-cycle (SETUP: psel=1, penable=0; ACCESS: psel=1, penable=1); no wait states; paddr/pwrite/pwdata stable across both cycles.
REQ-022 Outside SETUP/ACCESS, m_psel=m_penable=m_pwrite=0, m_paddr=0, m_pwdata=0.
REQ-023 States: IDLE, CFG_SETUP, CFG_ACCESS, RUN, POLL_SETUP, POLL_ACCESS, GAP, WR_SETUP, WR_ACCESS.
REQ-024 IDLE -> CFG_SETUP on start; start in any other state SHALL be ignored.
REQ-025 Configuration SHALL issue exactly five writes in order, step index 0..4: SE=0 (0x04), BRG=cfg_brg (0x08), CON=cfg_con (0x00), IE=cfg_ie (0x10), SE=cfg_se (0x04); SE=0 first so BRG write is accepted.
REQ-026 cfg_* SHALL be sampled into internal registers on the start cycle; later changes do not affect the running sequence.
REQ-027 CFG_ACCESS step 4 -> RUN; otherwise -> CFG_SETUP with step+1.
REQ-028 RUN -> POLL_SETUP when tx_valid=1; else stay.
REQ-029 POLL: read of 0x04 (pwrite=0); in POLL_ACCESS sample m_prdata[5]: 1 -> WR_SETUP, 0 -> GAP.
REQ-030 GAP SHALL last exactly POLL_GAP cycles (8-bit down-counter), then -> POLL_SETUP.
REQ-031 WR: write 0x04+0x08=offset 0x0C, pwdata={24'd0,tx_data}; tx_ready=1 only during WR_ACCESS; WR_ACCESS -> RUN.
REQ-032 Latency: tx_valid high in RUN at cycle N with FIFO not full -> tx_ready at cycle N+4; next byte back-to-back earliest tx_ready at N+9.
REQ-033 byte_cnt SHALL clear on start and increment on each tx_ready, wrapping 16'hFFFF -> 0.
REQ-034 stop asserted in RUN or GAP -> IDLE next cycle; in any SETUP state -> complete that transfer's ACCESS, then IDLE; stop and start in same IDLE cycle: start wins, stop ignored.
REQ-035 tx_valid dropping during POLL/GAP (protocol violation) SHALL abort to RUN without writing.
REQ-036 cfg_done=1 in RUN, POLL_*, GAP, WR_*; 0 in IDLE and CFG_*.

Reset
REQ-037 prst_n=0 SHALL asynchronously force IDLE, step=0, gap counter=0, byte_cnt=0, internal cfg copies=0, and all outputs 0, including mid-transfer.
REQ-038 First edge after prst_n deassertion SHALL behave as IDLE.

Verification
REQ-039 start with cfg_se=3'b001, cfg_brg=8'h1A, cfg_con=7'h05, cfg_ie=5'h03 -> writes (0x04,0),(0x08,0x1A),(0x00,0x05),(0x10,0x03),(0x04,0x01), 10 cycles, then cfg_done=1.
REQ-040 In RUN, tx_valid=1, tx_data=8'h55, prdata[5]=1 -> read 0x04, write 0x0C data 0x55, tx_ready at N+4, byte_cnt=1.
REQ-041 prdata[5]=0 for 3 polls then 1 -> each re-poll separated by POLL_GAP (4) idle cycles; single write, single tx_ready.
REQ-042 stop during WR_SETUP -> WR_ACCESS completes with tx_ready=1, then IDLE, busy=0.
REQ-043 prst_n low during CFG_ACCESS step 2 -> psel, penable, busy, cfg_done, byte_cnt all 0 immediately; new start restarts at step 0.
REQ-044 byte_cnt preset by 65535 accepted bytes -> next tx_ready wraps byte_cnt to 0.
